// File: rtl/dot_product_engine.sv
// dot_product_engine: strided dot product over two vectors in memory.
//
// This block fetches A[i] and B[i] one at a time through a read port that allows
// only one outstanding request. It accumulates the products in an ACC_W-bit
// register. When the last element is done it writes one DATA_W result word.
//
// Ports:
//   clk, resetn           clock, synchronous active-low reset
//   start_in              level; a rising edge in IDLE launches a job
//   signed_in, sat_in     element signedness, saturate-vs-truncate for the result
//   addr_a_in, addr_b_in  base byte addresses of vectors A and B
//   length_in             element count (0 writes a zero result)
//   addr_out_in           result byte address
//   status_out            [0] busy, [1] done, [2] overflow, [3] zero_len
//   read_*                single-outstanding read request/response port
//   write_*               result write request, held until write_done
module dot_product_engine #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ACC_W  = 64,
  parameter int unsigned STRIDE = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start_in,
  input  logic              signed_in,
  input  logic              sat_in,
  input  logic [ADDR_W-1:0] addr_a_in,
  input  logic [ADDR_W-1:0] addr_b_in,
  input  logic [31:0]       length_in,
  input  logic [ADDR_W-1:0] addr_out_in,
  output logic [31:0]       status_out,
  output logic              read_req,
  output logic [ADDR_W-1:0] read_addr,
  input  logic [DATA_W-1:0] read_data,
  input  logic              read_data_valid,
  output logic              write_req,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  input  logic              write_done
);

  typedef enum logic [2:0] {StIdle, StRdA, StRdB, StMac, StWr, StDone} state_e;

  localparam logic [ADDR_W-1:0] StrideInc = ADDR_W'(STRIDE);

  state_e              state_q, state_d;
  logic                start_q;
  logic [ADDR_W-1:0]   a_addr_q, a_addr_d, b_addr_q, b_addr_d, out_addr_q, out_addr_d;
  logic [31:0]         count_q, count_d;
  logic                signed_q, signed_d, sat_q, sat_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                read_req_q, read_req_d, write_req_q, write_req_d;
  logic [ADDR_W-1:0]   read_addr_q, read_addr_d, write_addr_q, write_addr_d;
  logic [DATA_W-1:0]   write_data_q, write_data_d;
  logic                busy_q, busy_d, done_q, done_d, ovf_q, ovf_d, zl_q, zl_d;

  logic                start_edge;
  logic [2*DATA_W-1:0] prod_s, prod_u;
  logic [ACC_W-1:0]    prod_ext, acc_next;
  logic [ACC_W-DATA_W:0]   hi_s;
  logic [ACC_W-DATA_W-1:0] hi_u;
  logic                fit_ovf;
  logic [DATA_W-1:0]   sat_val, fit_val;

  assign start_edge = start_in & ~start_q;

  // Operands are widened to 2*DATA_W first, so the low 2*DATA_W bits of the
  // product are exact in both modes.
  assign prod_s = $signed({{DATA_W{a_q[DATA_W-1]}}, a_q}) *
                  $signed({{DATA_W{b_q[DATA_W-1]}}, b_q});
  assign prod_u = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};
  assign prod_ext = signed_q ? ACC_W'($signed(prod_s)) : ACC_W'(prod_u);
  assign acc_next = acc_q + prod_ext;

  // Signed result fits only if the bits from DATA_W-1 upward are a pure sign extension.
  assign hi_s    = acc_next[ACC_W-1:DATA_W-1];
  assign hi_u    = acc_next[ACC_W-1:DATA_W];
  assign fit_ovf = signed_q ? ~((&hi_s) | (~|hi_s)) : (|hi_u);
  assign sat_val = !signed_q        ? {DATA_W{1'b1}} :
                   acc_next[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} :
                                       {1'b0, {(DATA_W-1){1'b1}}};
  assign fit_val = (fit_ovf && sat_q) ? sat_val : acc_next[DATA_W-1:0];

  always_comb begin
    state_d      = state_q;
    a_addr_d     = a_addr_q;
    b_addr_d     = b_addr_q;
    out_addr_d   = out_addr_q;
    count_d      = count_q;
    signed_d     = signed_q;
    sat_d        = sat_q;
    a_d          = a_q;
    b_d          = b_q;
    acc_d        = acc_q;
    read_req_d   = read_req_q;
    read_addr_d  = read_addr_q;
    write_req_d  = write_req_q;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    busy_d       = busy_q;
    done_d       = done_q;
    ovf_d        = ovf_q;
    zl_d         = zl_q;

    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          a_addr_d   = addr_a_in;
          b_addr_d   = addr_b_in;
          out_addr_d = addr_out_in;
          count_d    = length_in;
          signed_d   = signed_in;
          sat_d      = sat_in;
          acc_d      = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          ovf_d      = 1'b0;
          zl_d       = 1'b0;
          if (length_in != 32'd0) begin
            read_req_d  = 1'b1;
            read_addr_d = addr_a_in;
            state_d     = StRdA;
          end else begin
            zl_d         = 1'b1;
            write_req_d  = 1'b1;
            write_addr_d = addr_out_in;
            write_data_d = '0;
            state_d      = StWr;
          end
        end
      end
      StRdA: begin
        if (read_data_valid) begin
          a_d         = read_data;
          read_addr_d = b_addr_q;
          state_d     = StRdB;
        end
      end
      StRdB: begin
        if (read_data_valid) begin
          b_d        = read_data;
          read_req_d = 1'b0;
          state_d    = StMac;
        end
      end
      StMac: begin
        acc_d   = acc_next;
        count_d = count_q - 32'd1;
        if (count_q == 32'd1) begin
          write_req_d  = 1'b1;
          write_addr_d = out_addr_q;
          write_data_d = fit_val;
          ovf_d        = fit_ovf;
          state_d      = StWr;
        end else begin
          a_addr_d    = a_addr_q + StrideInc;
          b_addr_d    = b_addr_q + StrideInc;
          read_req_d  = 1'b1;
          read_addr_d = a_addr_q + StrideInc;
          state_d     = StRdA;
        end
      end
      StWr: begin
        if (write_done) begin
          write_req_d = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          state_d     = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= StIdle;
      start_q      <= 1'b0;
      a_addr_q     <= '0;
      b_addr_q     <= '0;
      out_addr_q   <= '0;
      count_q      <= '0;
      signed_q     <= 1'b0;
      sat_q        <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      acc_q        <= '0;
      read_req_q   <= 1'b0;
      read_addr_q  <= '0;
      write_req_q  <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      zl_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_in;
      a_addr_q     <= a_addr_d;
      b_addr_q     <= b_addr_d;
      out_addr_q   <= out_addr_d;
      count_q      <= count_d;
      signed_q     <= signed_d;
      sat_q        <= sat_d;
      a_q          <= a_d;
      b_q          <= b_d;
      acc_q        <= acc_d;
      read_req_q   <= read_req_d;
      read_addr_q  <= read_addr_d;
      write_req_q  <= write_req_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
      zl_q         <= zl_d;
    end
  end

  assign status_out = {28'd0, zl_q, ovf_q, done_q, busy_q};
  assign read_req   = read_req_q;
  assign read_addr  = read_addr_q;
  assign write_req  = write_req_q;
  assign write_addr = write_addr_q;
  assign write_data = write_data_q;

endmodule

// File: tb/tb_dot_product_engine.sv
// Scoreboard bench for dot_product_engine: the stimulus pushes expected read
// addresses, result writes and final status words into queues. A negedge
// monitor pops them and compares them as the DUT presents each transaction.
module tb_dot_product_engine;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start_in, signed_in, sat_in;
  logic [31:0] addr_a_in, addr_b_in, length_in, addr_out_in;
  logic [31:0] status_out;
  logic        read_req;
  logic [31:0] read_addr;
  logic [31:0] read_data;
  logic        read_data_valid;
  logic        write_req;
  logic [31:0] write_addr, write_data;
  logic        write_done;

  dot_product_engine dut (
    .clk             (clk),
    .resetn          (resetn),
    .start_in        (start_in),
    .signed_in       (signed_in),
    .sat_in          (sat_in),
    .addr_a_in       (addr_a_in),
    .addr_b_in       (addr_b_in),
    .length_in       (length_in),
    .addr_out_in     (addr_out_in),
    .status_out      (status_out),
    .read_req        (read_req),
    .read_addr       (read_addr),
    .read_data       (read_data),
    .read_data_valid (read_data_valid),
    .write_req       (write_req),
    .write_addr      (write_addr),
    .write_data      (write_data),
    .write_done      (write_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  bit [31:0] mem [bit [31:0]];
  logic [31:0] exp_rd_q[$];
  logic [31:0] exp_wa_q[$];
  logic [31:0] exp_wd_q[$];
  logic [31:0] exp_st_q[$];

  int rd_max = 0, wr_max = 0;
  int rd_wait = -1, wr_wait = -1;
  bit rd_inject = 0, wr_inject = 0;
  bit rd_stall_en = 0;
  logic [31:0] stall_addr = 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick(input int mx);
    return (mx == 0) ? 0 : int'($urandom_range(mx, 0));
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  // Read responder: one valid per request after a 0..rd_max cycle delay.
  always @(negedge clk) begin
    if (rd_inject) begin
      read_data_valid = 1'b1;
      read_data       = 32'hDEADBEEF;
    end else if (!read_req || (rd_stall_en && read_addr == stall_addr)) begin
      read_data_valid = 1'b0;
      rd_wait         = -1;
    end else begin
      if (rd_wait < 0 || read_data_valid) rd_wait = pick(rd_max);
      read_data_valid = 1'b0;
      if (rd_wait == 0) begin
        read_data_valid = 1'b1;
        read_data       = mem_rd(read_addr);
      end else begin
        rd_wait--;
      end
    end
  end

  // Write responder: write_done after a 0..wr_max cycle delay.
  always @(negedge clk) begin
    if (wr_inject) begin
      write_done = 1'b1;
    end else if (!write_req) begin
      write_done = 1'b0;
      wr_wait    = -1;
    end else begin
      if (wr_wait < 0 || write_done) wr_wait = pick(wr_max);
      write_done = 1'b0;
      if (wr_wait == 0) write_done = 1'b1;
      else wr_wait--;
    end
  end

  // Monitor
  logic        prev_rreq = 0, prev_rvalid = 0, prev_wreq = 0, prev_wdone = 0, prev_done = 0;
  logic [31:0] prev_raddr = 0, prev_waddr = 0, prev_wdata = 0;
  always @(negedge clk) begin
    #1;
    if (resetn) begin
      if (read_req && read_data_valid) begin
        if (exp_rd_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_read: got addr %0h expected no read", read_addr);
        end else begin
          check("read_addr", read_addr, exp_rd_q.pop_front());
        end
      end
      if (read_req && prev_rreq && !prev_rvalid) check("read_addr_stable", read_addr, prev_raddr);
      if (write_req && prev_wreq && !prev_wdone) begin
        check("write_addr_stable", write_addr, prev_waddr);
        check("write_data_stable", write_data, prev_wdata);
      end
      if (write_req && write_done) begin
        if (exp_wa_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: got addr %0h expected no write", write_addr);
        end else begin
          check("write_addr", write_addr, exp_wa_q.pop_front());
          check("write_data", write_data, exp_wd_q.pop_front());
        end
      end
      if (status_out[1] && !prev_done) begin
        if (exp_st_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: got status %0h expected none", status_out);
        end else begin
          check("final_status", status_out, exp_st_q.pop_front());
        end
      end
    end
    prev_rreq   = read_req;
    prev_rvalid = read_data_valid;
    prev_raddr  = read_addr;
    prev_wreq   = write_req;
    prev_wdone  = write_done;
    prev_waddr  = write_addr;
    prev_wdata  = write_data;
    prev_done   = status_out[1];
  end

  task automatic run_job(input logic [31:0] a_base, input logic [31:0] b_base,
                         input logic [31:0] o_addr, input logic [31:0] len,
                         input bit sgn, input bit sat,
                         input logic [31:0] av[4], input logic [31:0] bv[4],
                         input logic [31:0] exp_data, input logic [31:0] exp_status,
                         input bit repulse);
    for (int i = 0; i < int'(len); i++) begin
      mem[a_base + 32'(i * 8)] = av[i];
      mem[b_base + 32'(i * 8)] = bv[i];
      exp_rd_q.push_back(a_base + 32'(i * 8));
      exp_rd_q.push_back(b_base + 32'(i * 8));
    end
    exp_wa_q.push_back(o_addr);
    exp_wd_q.push_back(exp_data);
    exp_st_q.push_back(exp_status);
    @(negedge clk);
    addr_a_in   = a_base;
    addr_b_in   = b_base;
    addr_out_in = o_addr;
    length_in   = len;
    signed_in   = sgn;
    sat_in      = sat;
    start_in    = 1'b1;
    @(negedge clk);
    #2;
    check("busy_after_start", status_out[0], 1);
    start_in = 1'b0;
    if (repulse) begin
      repeat (3) @(negedge clk);
      start_in = 1'b1;
    end
    for (int c = 0; c < 3000 && exp_st_q.size() != 0; c++) @(negedge clk);
    if (exp_st_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL job_timeout: got %0d results pending expected 0", exp_st_q.size());
      exp_st_q.delete();
      exp_wa_q.delete();
      exp_wd_q.delete();
    end
    check("reads_left", exp_rd_q.size(), 0);
    exp_rd_q.delete();
    repeat (2) @(negedge clk);
    start_in = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  logic [31:0] va[4], vb[4];

  initial begin
    resetn = 1'b0;
    start_in = 0; signed_in = 0; sat_in = 0;
    addr_a_in = 0; addr_b_in = 0; length_in = 0; addr_out_in = 0;
    read_data = 0; read_data_valid = 0; write_done = 0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_status", status_out, 0);
    check("rst_read_req", read_req, 0);
    check("rst_read_addr", read_addr, 0);
    check("rst_write_req", write_req, 0);
    check("rst_write_addr", write_addr, 0);
    check("rst_write_data", write_data, 0);
    resetn = 1'b1;

    // Basic signed job: 1*5+2*6+3*7+4*8 = 70
    va = '{32'd1, 32'd2, 32'd3, 32'd4};
    vb = '{32'd5, 32'd6, 32'd7, 32'd8};
    run_job(32'h100, 32'h200, 32'h300, 4, 1, 0, va, vb, 32'd70, 32'h2, 0);

    // Signed negatives: -3*4 + 7*-2 = -26
    va = '{32'hFFFFFFFD, 32'd7, 32'd0, 32'd0};
    vb = '{32'd4, 32'hFFFFFFFE, 32'd0, 32'd0};
    run_job(32'h400, 32'h480, 32'h500, 2, 1, 0, va, vb, 32'hFFFFFFE6, 32'h2, 0);

    // Unsigned overflow, saturate and truncate
    va = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
    vb = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
    run_job(32'h600, 32'h700, 32'h800, 2, 0, 1, va, vb, 32'hFFFFFFFF, 32'h6, 0);
    run_job(32'h600, 32'h700, 32'h804, 2, 0, 0, va, vb, 32'h00000002, 32'h6, 0);

    // Zero length: no reads, single zero write
    run_job(32'h900, 32'hA00, 32'hB00, 0, 1, 1, va, vb, 32'h0, 32'hA, 0);

    // Signed negative saturation: 2 * (-2^31 * (2^31-1)) clamps to 0x80000000
    va = '{32'h80000000, 32'h80000000, 32'd0, 32'd0};
    vb = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'd0, 32'd0};
    run_job(32'hC00, 32'hD00, 32'hE00, 2, 1, 1, va, vb, 32'h80000000, 32'h6, 0);

    // Random handshake delays and a start re-pulse while busy
    rd_max = 7;
    wr_max = 7;
    va = '{32'd1, 32'd2, 32'd3, 32'd4};
    vb = '{32'd5, 32'd6, 32'd7, 32'd8};
    run_job(32'h100, 32'h200, 32'h300, 4, 1, 0, va, vb, 32'd70, 32'h2, 1);
    va = '{32'h80000000, 32'h80000000, 32'd0, 32'd0};
    vb = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'd0, 32'd0};
    run_job(32'hC00, 32'hD00, 32'hE00, 2, 1, 1, va, vb, 32'h80000000, 32'h6, 0);
    run_job(32'h900, 32'hA00, 32'hB00, 0, 0, 0, va, vb, 32'h0, 32'hA, 0);
    rd_max = 0;
    wr_max = 0;

    // Reset while stalled in RD_B of a length-3 job
    mem[32'h1000] = 32'd2; mem[32'h1008] = 32'd3; mem[32'h1010] = 32'd4;
    mem[32'h2000] = 32'd5; mem[32'h2008] = 32'd6; mem[32'h2010] = 32'd7;
    exp_rd_q.push_back(32'h1000);
    stall_addr  = 32'h2000;
    rd_stall_en = 1;
    @(negedge clk);
    addr_a_in = 32'h1000; addr_b_in = 32'h2000; addr_out_in = 32'h3000;
    length_in = 3; signed_in = 0; sat_in = 0; start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    begin
      bit found = 0;
      for (int c = 0; c < 100 && !found; c++) begin
        @(negedge clk);
        #2;
        if (read_req && read_addr == 32'h2000) found = 1;
      end
      if (!found) begin
        n_cmp++;
        n_err++;
        $display("FAIL reach_rd_b: got no B read request expected one");
      end
    end
    repeat (2) @(negedge clk);
    #2;
    resetn = 1'b0;
    @(negedge clk);
    #2;
    resetn = 1'b1;
    check("midrst_status", status_out, 0);
    check("midrst_read_req", read_req, 0);
    check("midrst_read_addr", read_addr, 0);
    check("midrst_write_req", write_req, 0);
    check("midrst_reads_left", exp_rd_q.size(), 0);
    exp_rd_q.delete();
    rd_inject = 1;
    wr_inject = 1;
    @(negedge clk);
    #2;
    rd_inject = 0;
    wr_inject = 0;
    repeat (2) @(negedge clk);
    #2;
    check("late_valid_status", status_out, 0);
    check("late_valid_read_req", read_req, 0);
    check("late_valid_write_req", write_req, 0);
    rd_stall_en = 0;

    // Clean job after reset starts from acc=0
    va = '{32'd1, 32'd2, 32'd3, 32'd4};
    vb = '{32'd5, 32'd6, 32'd7, 32'd8};
    run_job(32'h100, 32'h200, 32'h300, 4, 1, 0, va, vb, 32'd70, 32'h2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
